// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch stage and its pre-decoder.
package fetch_queue_pkg;

  localparam int unsigned INSN_W       = 32;
  localparam int unsigned GPR_SIZE_DEF = 64;

  localparam logic [INSN_W-1:0] INSN_HLT = 32'hD440_0000;

  localparam int unsigned COND_ALWAYS = 0;
  localparam int unsigned COND_BTFN   = 1;
  localparam int unsigned COND_NEVER  = 2;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_UNCOND,
    BR_COND,
    BR_HALT
  } branch_class_t;

  typedef enum logic {
    ST_FETCH,
    ST_HALTED
  } fetch_state_t;

  // PC fields are GPR_SIZE_DEF wide; narrower GPR_SIZE values are zero-extended into them.
  typedef struct packed {
    logic [INSN_W-1:0]       insnbits;
    logic [GPR_SIZE_DEF-1:0] pc;
    logic                    pred_taken;
    logic [GPR_SIZE_DEF-1:0] branch_pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational branch pre-decoder: classifies an instruction word and computes its PC-relative target.
module fetch_predecode
  import fetch_queue_pkg::*;
#(
  parameter int unsigned GPR_SIZE = GPR_SIZE_DEF
) (
  input  logic [INSN_W-1:0]   in_insnbits,
  input  logic [GPR_SIZE-1:0] in_pc,
  output branch_class_t       out_class_c,
  output logic [GPR_SIZE-1:0] out_target_c
);

  logic [GPR_SIZE-1:0] w_offset;

  always_comb begin
    out_class_c = BR_NONE;
    w_offset    = '0;
    if (in_insnbits == INSN_HLT) begin
      out_class_c = BR_HALT;
    end else if (in_insnbits[31:26] == 6'b000101 || in_insnbits[31:26] == 6'b100101) begin
      out_class_c = BR_UNCOND;
      w_offset    = {{(GPR_SIZE-28){in_insnbits[25]}}, in_insnbits[25:0], 2'b00};
    end else if (in_insnbits[31:24] == 8'b0101_0100 && !in_insnbits[4]) begin
      out_class_c = BR_COND;
      w_offset    = {{(GPR_SIZE-21){in_insnbits[23]}}, in_insnbits[23:5], 2'b00};
    end
  end

  assign out_target_c = in_pc + w_offset;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC generation, static branch prediction and a DEPTH-entry queue to decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned          DEPTH     = 4,
  parameter int unsigned          GPR_SIZE  = GPR_SIZE_DEF,
  parameter logic [GPR_SIZE-1:0]  ENTRY_PC  = '0,
  parameter int unsigned          COND_MODE = COND_ALWAYS
) (
  input  logic                in_clk,
  input  logic                in_rst_n,
  input  logic                in_rob_mispredict,
  input  logic [GPR_SIZE-1:0] in_rob_new_PC,
  output logic [GPR_SIZE-1:0] out_imem_addr,
  input  logic [INSN_W-1:0]   in_imem_data,
  output logic                out_d_valid,
  input  logic                in_d_ready,
  output logic [INSN_W-1:0]   out_d_insnbits,
  output logic [GPR_SIZE-1:0] out_d_PC,
  output logic                out_d_pred_taken,
  output logic [GPR_SIZE-1:0] out_d_branch_PC,
  output logic                out_halted
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_state_t        r_state;
  logic [GPR_SIZE-1:0] r_pc;
  logic [PW-1:0]       r_head;
  logic [PW-1:0]       r_tail;
  logic [CW-1:0]       r_count;
  fetch_entry_t        r_mem [DEPTH];

  branch_class_t       w_class;
  logic [GPR_SIZE-1:0] w_target;
  logic [GPR_SIZE-1:0] w_pc_seq;
  logic [GPR_SIZE-1:0] w_next_pc;
  logic [GPR_SIZE-1:0] w_alt_pc;
  logic                w_pred;
  logic                w_cond_taken;
  logic                w_deq;
  logic                w_enq;

  fetch_predecode #(
    .GPR_SIZE(GPR_SIZE)
  ) u_predecode (
    .in_insnbits (in_imem_data),
    .in_pc       (r_pc),
    .out_class_c (w_class),
    .out_target_c(w_target)
  );

  assign w_pc_seq = r_pc + GPR_SIZE'(4);

  // Static prediction: pick the fetch successor and the alternate PC handed to the ROB.
  always_comb begin
    w_cond_taken = 1'b1;
    if (COND_MODE == COND_BTFN) begin
      w_cond_taken = in_imem_data[23];
    end else if (COND_MODE == COND_NEVER) begin
      w_cond_taken = 1'b0;
    end
    w_pred    = 1'b0;
    w_next_pc = w_pc_seq;
    w_alt_pc  = w_pc_seq;
    case (w_class)
      BR_UNCOND: begin
        w_pred    = 1'b1;
        w_next_pc = w_target;
        w_alt_pc  = w_target;
      end
      BR_COND: begin
        w_pred = w_cond_taken;
        if (w_cond_taken) begin
          w_next_pc = w_target;
        end else begin
          w_alt_pc = w_target;
        end
      end
      default: ;
    endcase
  end

  assign w_deq = (r_count != '0) && in_d_ready;
  assign w_enq = (r_state == ST_FETCH) && !in_rob_mispredict &&
                 ((r_count < CW'(DEPTH)) || w_deq);

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_state <= ST_FETCH;
      r_pc    <= ENTRY_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (in_rob_mispredict) begin
      r_state <= ST_FETCH;
      r_pc    <= in_rob_new_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_mem[r_tail] <= '{insnbits:   in_imem_data,
                           pc:         GPR_SIZE_DEF'(r_pc),
                           pred_taken: w_pred,
                           branch_pc:  GPR_SIZE_DEF'(w_alt_pc)};
        r_tail        <= r_tail + PW'(1);
        r_pc          <= w_next_pc;
        if (w_class == BR_HALT) begin
          r_state <= ST_HALTED;
        end
      end
      if (w_deq) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  assign out_imem_addr    = r_pc;
  assign out_d_valid      = (r_count != '0);
  assign out_d_insnbits   = r_mem[r_head].insnbits;
  assign out_d_PC         = GPR_SIZE'(r_mem[r_head].pc);
  assign out_d_pred_taken = r_mem[r_head].pred_taken;
  assign out_d_branch_PC  = GPR_SIZE'(r_mem[r_head].branch_pc);
  assign out_halted       = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: three instances share stimulus and IMEM, one per B.cond policy.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        misp;
  logic [63:0] new_pc;
  logic        ready;
  logic [31:0] mem [0:16383];

  logic [63:0] addr0, addr1, addr2;
  logic [31:0] data0, data1, data2;
  logic        valid0, valid1, valid2;
  logic [31:0] insn0, insn1, insn2;
  logic [63:0] pc0, pc1, pc2;
  logic        pred0, pred1, pred2;
  logic [63:0] bpc0, bpc1, bpc2;
  logic        halted0, halted1, halted2;

  int vectors = 0;
  int misses  = 0;

  localparam logic [31:0] NOP = 32'hD503_201F;
  localparam logic [31:0] HLT = 32'hD440_0000;

  always #5 clk = ~clk;

  assign data0 = mem[addr0[15:2]];
  assign data1 = mem[addr1[15:2]];
  assign data2 = mem[addr2[15:2]];

  fetch_queue #(.DEPTH(4), .GPR_SIZE(64), .ENTRY_PC(64'h1000), .COND_MODE(0)) dut0 (
    .in_clk(clk), .in_rst_n(rst_n), .in_rob_mispredict(misp), .in_rob_new_PC(new_pc),
    .out_imem_addr(addr0), .in_imem_data(data0), .out_d_valid(valid0), .in_d_ready(ready),
    .out_d_insnbits(insn0), .out_d_PC(pc0), .out_d_pred_taken(pred0),
    .out_d_branch_PC(bpc0), .out_halted(halted0));

  fetch_queue #(.DEPTH(4), .GPR_SIZE(64), .ENTRY_PC(64'h1000), .COND_MODE(1)) dut1 (
    .in_clk(clk), .in_rst_n(rst_n), .in_rob_mispredict(misp), .in_rob_new_PC(new_pc),
    .out_imem_addr(addr1), .in_imem_data(data1), .out_d_valid(valid1), .in_d_ready(ready),
    .out_d_insnbits(insn1), .out_d_PC(pc1), .out_d_pred_taken(pred1),
    .out_d_branch_PC(bpc1), .out_halted(halted1));

  fetch_queue #(.DEPTH(4), .GPR_SIZE(64), .ENTRY_PC(64'h1000), .COND_MODE(2)) dut2 (
    .in_clk(clk), .in_rst_n(rst_n), .in_rob_mispredict(misp), .in_rob_new_PC(new_pc),
    .out_imem_addr(addr2), .in_imem_data(data2), .out_d_valid(valid2), .in_d_ready(ready),
    .out_d_insnbits(insn2), .out_d_PC(pc2), .out_d_pred_taken(pred2),
    .out_d_branch_PC(bpc2), .out_halted(halted2));

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) mem[i] = NOP;
  endtask

  task automatic set_word(input logic [63:0] a, input logic [31:0] w);
    mem[a[15:2]] = w;
  endtask

  // Ends on a negedge with reset just released; first enqueue happens at the next posedge.
  task automatic apply_reset(input logic rdy);
    rst_n = 1'b0;
    misp  = 1'b0;
    ready = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Ends on the negedge right after the redirect target has been enqueued.
  task automatic redirect(input logic [63:0] target);
    misp   = 1'b1;
    new_pc = target;
    @(negedge clk);
    misp = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; misp = 1'b1; new_pc = 64'h7000; ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (valid0 !== 1'b0) begin misses++; $display("FAIL rst_valid got %b exp 0", valid0); end
    vectors++; if (halted0 !== 1'b0) begin misses++; $display("FAIL rst_halted got %b exp 0", halted0); end
    vectors++; if (addr0 !== 64'h1000) begin misses++; $display("FAIL rst_addr got %h exp 1000", addr0); end
    vectors++; if (pc0 !== 64'h0 || insn0 !== 32'h0 || bpc0 !== 64'h0 || pred0 !== 1'b0) begin
      misses++; $display("FAIL rst_fields got pc %h insn %h bpc %h pred %b exp all 0", pc0, insn0, bpc0, pred0);
    end
    misp = 1'b0;
  endtask

  task automatic test_sequential();
    clear_mem();
    apply_reset(1'b1);
    vectors++; if (valid0 !== 1'b0) begin misses++; $display("FAIL seq_valid_early got %b exp 0", valid0); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (valid0 !== 1'b1 || pc0 !== 64'h1000 + 64'(4 * i)) begin
        misses++; $display("FAIL seq_pc[%0d] got v%b %h exp v1 %h", i, valid0, pc0, 64'h1000 + 64'(4 * i));
      end
    end
  endtask

  task automatic test_branch();
    clear_mem();
    set_word(64'h1000, 32'h1400_0004);
    set_word(64'h1010, 32'h97FF_FFFC);
    apply_reset(1'b1);
    @(negedge clk);
    vectors++; if (pc0 !== 64'h1000 || pred0 !== 1'b1 || bpc0 !== 64'h1010 || insn0 !== 32'h1400_0004) begin
      misses++; $display("FAIL b_entry got pc %h pred %b bpc %h insn %h exp 1000 1 1010 14000004", pc0, pred0, bpc0, insn0);
    end
    @(negedge clk);
    vectors++; if (pc0 !== 64'h1010 || pred0 !== 1'b1 || bpc0 !== 64'h1000) begin
      misses++; $display("FAIL bl_entry got pc %h pred %b bpc %h exp 1010 1 1000", pc0, pred0, bpc0);
    end
    @(negedge clk);
    vectors++; if (pc0 !== 64'h1000 || pred0 !== 1'b1) begin
      misses++; $display("FAIL bl_target got pc %h pred %b exp 1000 1", pc0, pred0);
    end
  endtask

  task automatic test_cond_modes();
    clear_mem();
    apply_reset(1'b0);
    set_word(64'h2000, 32'h54FF_FFC0);
    redirect(64'h2000);
    vectors++; if (pc0 !== 64'h2000 || pred0 !== 1'b1 || addr0 !== 64'h1FF8 || bpc0 !== 64'h2004) begin
      misses++; $display("FAIL bc_back_m0 got pc %h pred %b next %h bpc %h exp 2000 1 1ff8 2004", pc0, pred0, addr0, bpc0);
    end
    vectors++; if (pc1 !== 64'h2000 || pred1 !== 1'b1 || addr1 !== 64'h1FF8 || bpc1 !== 64'h2004) begin
      misses++; $display("FAIL bc_back_m1 got pc %h pred %b next %h bpc %h exp 2000 1 1ff8 2004", pc1, pred1, addr1, bpc1);
    end
    vectors++; if (pred2 !== 1'b0 || addr2 !== 64'h2004 || bpc2 !== 64'h1FF8) begin
      misses++; $display("FAIL bc_back_m2 got pred %b next %h bpc %h exp 0 2004 1ff8", pred2, addr2, bpc2);
    end
    set_word(64'h2000, 32'h5400_0080);
    redirect(64'h2000);
    vectors++; if (pred0 !== 1'b1 || addr0 !== 64'h2010 || bpc0 !== 64'h2004) begin
      misses++; $display("FAIL bc_fwd_m0 got pred %b next %h bpc %h exp 1 2010 2004", pred0, addr0, bpc0);
    end
    vectors++; if (pc1 !== 64'h2000 || pred1 !== 1'b0 || addr1 !== 64'h2004 || bpc1 !== 64'h2010) begin
      misses++; $display("FAIL bc_fwd_m1 got pc %h pred %b next %h bpc %h exp 2000 0 2004 2010", pc1, pred1, addr1, bpc1);
    end
    vectors++; if (pred2 !== 1'b0 || addr2 !== 64'h2004 || bpc2 !== 64'h2010) begin
      misses++; $display("FAIL bc_fwd_m2 got pred %b next %h bpc %h exp 0 2004 2010", pred2, addr2, bpc2);
    end
    set_word(64'h2000, 32'h5400_0090);
    redirect(64'h2000);
    vectors++; if (pred0 !== 1'b0 || addr0 !== 64'h2004 || bpc0 !== 64'h2004) begin
      misses++; $display("FAIL bc_bit4 got pred %b next %h bpc %h exp 0 2004 2004", pred0, addr0, bpc0);
    end
  endtask

  task automatic test_backpressure();
    clear_mem();
    apply_reset(1'b0);
    repeat (4) @(negedge clk);
    vectors++; if (addr0 !== 64'h1010 || valid0 !== 1'b1 || pc0 !== 64'h1000) begin
      misses++; $display("FAIL bp_full got addr %h v%b head %h exp 1010 v1 1000", addr0, valid0, pc0);
    end
    @(negedge clk);
    vectors++; if (addr0 !== 64'h1010) begin misses++; $display("FAIL bp_hold got %h exp 1010", addr0); end
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vectors++; if (valid0 !== 1'b1 || pc0 !== 64'h1000 + 64'(4 * i)) begin
        misses++; $display("FAIL bp_drain[%0d] got v%b %h exp v1 %h", i, valid0, pc0, 64'h1000 + 64'(4 * i));
      end
      @(negedge clk);
      if (i == 0) begin
        vectors++; if (addr0 !== 64'h1014) begin misses++; $display("FAIL bp_full_deq_enq got %h exp 1014", addr0); end
      end
    end
  endtask

  task automatic test_mispredict();
    clear_mem();
    apply_reset(1'b0);
    repeat (3) @(negedge clk);
    vectors++; if (addr0 !== 64'h100C) begin misses++; $display("FAIL mp_pre got %h exp 100c", addr0); end
    misp = 1'b1; new_pc = 64'h3000; ready = 1'b1;
    @(negedge clk);
    misp = 1'b0;
    vectors++; if (valid0 !== 1'b0 || addr0 !== 64'h3000) begin
      misses++; $display("FAIL mp_flush got v%b addr %h exp v0 3000", valid0, addr0);
    end
    @(negedge clk);
    vectors++; if (valid0 !== 1'b1 || pc0 !== 64'h3000) begin
      misses++; $display("FAIL mp_head got v%b %h exp v1 3000", valid0, pc0);
    end
  endtask

  task automatic test_halt();
    clear_mem();
    set_word(64'h1008, HLT);
    apply_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (valid0 !== 1'b1 || pc0 !== 64'h1000 + 64'(4 * i) || halted0 !== (i == 2)) begin
        misses++; $display("FAIL hlt_deliver[%0d] got v%b %h h%b exp v1 %h h%b", i, valid0, pc0, halted0,
                           64'h1000 + 64'(4 * i), (i == 2));
      end
    end
    vectors++; if (insn0 !== HLT) begin misses++; $display("FAIL hlt_insn got %h exp %h", insn0, HLT); end
    repeat (3) @(negedge clk);
    vectors++; if (valid0 !== 1'b0 || halted0 !== 1'b1 || addr0 !== 64'h100C) begin
      misses++; $display("FAIL hlt_stopped got v%b h%b addr %h exp v0 h1 100c", valid0, halted0, addr0);
    end
    misp = 1'b1; new_pc = 64'h4000;
    @(negedge clk);
    misp = 1'b0;
    vectors++; if (halted0 !== 1'b0 || valid0 !== 1'b0) begin
      misses++; $display("FAIL hlt_resume got h%b v%b exp h0 v0", halted0, valid0);
    end
    @(negedge clk);
    vectors++; if (valid0 !== 1'b1 || pc0 !== 64'h4000) begin
      misses++; $display("FAIL hlt_resume_head got v%b %h exp v1 4000", valid0, pc0);
    end
  endtask

  task automatic test_reset_mid_halt();
    redirect(64'h1008);
    vectors++; if (halted0 !== 1'b1 || pc0 !== 64'h1008) begin
      misses++; $display("FAIL rmh_halt got h%b %h exp h1 1008", halted0, pc0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (halted0 !== 1'b0 || valid0 !== 1'b0 || pc0 !== 64'h0 || addr0 !== 64'h1000) begin
      misses++; $display("FAIL rmh_clear got h%b v%b pc %h addr %h exp h0 v0 0 1000", halted0, valid0, pc0, addr0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (valid0 !== 1'b1 || pc0 !== 64'h1000) begin
      misses++; $display("FAIL rmh_restart got v%b %h exp v1 1000", valid0, pc0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    new_pc = 64'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_cond_modes();
    test_backpressure();
    test_mispredict();
    test_halt();
    test_reset_mid_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
